// File: rtl/nibble_sda_tx_if.sv
// Handshake and two-wire bus bundle for nibble_sda_tx.
// scl_in (bus clock readback) is present only when NIBBLE_SDA_TX_STRETCH_EN is defined.
interface nibble_sda_tx_if;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic       scl;
  logic       sda;
`ifdef NIBBLE_SDA_TX_STRETCH_EN
  logic       scl_in;

  modport master (output data, valid, scl_in, input ready, busy, done, scl, sda);
  modport slave  (input data, valid, scl_in, output ready, busy, done, scl, sda);
`else
  modport master (output data, valid, input ready, busy, done, scl, sda);
  modport slave  (input data, valid, output ready, busy, done, scl, sda);
`endif
endinterface

// File: rtl/nibble_sda_tx.sv
// Serialises a 4-bit nibble onto scl/sda: start, 4 bits MSB first, tail clock, stop.
// Define NIBBLE_SDA_TX_STRETCH_EN to let a low scl_in stretch the scl-high phases.
module nibble_sda_tx #(
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  nibble_sda_tx_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, START, BIT_LO, BIT_HI, TAIL_LO, TAIL_HI, STOP_LO, STOP_HI, STOP_REL
  } state_t;

  localparam logic [15:0] LAST = 16'(DIV - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  shift, shift_nxt;
  logic [1:0]  bit_cnt, bit_cnt_nxt;
  logic        scl_r, sda_r, done_r;
  logic        scl_nxt, sda_nxt, done_nxt;
  logic        hold, phase_end, settle;

`ifdef NIBBLE_SDA_TX_STRETCH_EN
  assign hold = !bus.scl_in && (state == BIT_HI || state == TAIL_HI || state == STOP_HI);
`else
  assign hold = 1'b0;
`endif
  assign phase_end = !hold && (cnt == LAST);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
    if (state == IDLE) begin
      cnt_nxt = '0;
      if (bus.valid) begin
        state_nxt   = START;
        shift_nxt   = bus.data;
        bit_cnt_nxt = '0;
      end
    end else if (phase_end) begin
      cnt_nxt = '0;
      unique case (state)
        START:    state_nxt = BIT_LO;
        BIT_LO:   state_nxt = BIT_HI;
        BIT_HI: begin
          shift_nxt   = {shift[2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 2'd1;
          state_nxt   = (bit_cnt == 2'd3) ? TAIL_LO : BIT_LO;
        end
        TAIL_LO:  state_nxt = TAIL_HI;
        TAIL_HI:  state_nxt = STOP_LO;
        STOP_LO:  state_nxt = STOP_HI;
        STOP_HI:  state_nxt = STOP_REL;
        STOP_REL: begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
        default:  state_nxt = IDLE;
      endcase
    end else if (!hold) begin
      cnt_nxt = cnt + 16'd1;
    end
  end

  // sda moves one cycle after scl falls so it never switches on an scl edge;
  // with DIV=1 there is no spare cycle and it follows the phase directly.
  always_comb begin
    scl_nxt = 1'b1;
    sda_nxt = 1'b1;
    settle  = (DIV == 1) || (cnt_nxt != 16'd0);
    unique case (state_nxt)
      START: sda_nxt = 1'b0;
      BIT_LO: begin
        scl_nxt = 1'b0;
        sda_nxt = settle ? shift_nxt[3] : sda_r;
      end
      BIT_HI:  sda_nxt = sda_r;
      TAIL_LO: begin
        scl_nxt = 1'b0;
        sda_nxt = settle ? 1'b0 : sda_r;
      end
      TAIL_HI: sda_nxt = 1'b0;
      STOP_LO: begin
        scl_nxt = 1'b0;
        sda_nxt = 1'b0;
      end
      STOP_HI: sda_nxt = 1'b0;
      default: begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_cnt <= '0;
      scl_r   <= 1'b1;
      sda_r   <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      scl_r   <= scl_nxt;
      sda_r   <= sda_nxt;
      done_r  <= done_nxt;
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_r;
  assign bus.scl   = scl_r;
  assign bus.sda   = sda_r;

endmodule

// File: tb/tb_nibble_sda_tx.sv
// Bench for nibble_sda_tx: DIV=4 and DIV=1 instances checked every cycle against
// a phase-table model, plus directed frame, reset and (optional) stretch scenarios.
module tb_nibble_sda_tx;
  localparam int DIVA = 4;
  localparam int DIVB = 1;
  localparam int LOGN = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_v [2];
  logic [3:0] data_v  [2];
  logic [4:0] obs     [2];
  logic [4:0] lg      [2][LOGN];
  int         m_k     [2] = '{-1, -1};
  logic [3:0] m_d     [2] = '{4'd0, 4'd0};
  logic       stretch_v = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;

  nibble_sda_tx_if ifa ();
  nibble_sda_tx_if ifb ();

  nibble_sda_tx #(.DIV(DIVA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  nibble_sda_tx #(.DIV(DIVB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifa.valid = valid_v[0];
  assign ifa.data  = data_v[0];
  assign ifb.valid = valid_v[1];
  assign ifb.data  = data_v[1];
`ifdef NIBBLE_SDA_TX_STRETCH_EN
  assign ifa.scl_in = ifa.scl & ~stretch_v;
  assign ifb.scl_in = ifb.scl;
`endif
  assign obs[0] = {ifa.scl, ifa.sda, ifa.ready, ifa.busy, ifa.done};
  assign obs[1] = {ifb.scl, ifb.sda, ifb.ready, ifb.busy, ifb.done};

  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    return (i == 0) ? DIVA : DIVB;
  endfunction

  // {scl, sda} of phase p: 0 start, 1..8 bit lo/hi pairs, 9/10 tail, 11/12 stop, 13 release
  function automatic logic [1:0] phase_lvl(input int p, input logic [3:0] d);
    if (p == 0) return 2'b10;
    if (p <= 8) return {1'((p - 1) % 2), d[3 - (p - 1) / 2]};
    case (p)
      9:       return 2'b00;
      10:      return 2'b10;
      11:      return 2'b00;
      12:      return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Expected {scl, sda, ready, busy, done}; k = cycles since START began, -1 when idle
  function automatic logic [4:0] model_out(input int i, input int k, input logic [3:0] d);
    int dv, p;
    logic [1:0] lv;
    dv = div_of(i);
    if (k < 0) return 5'b11100;
    if (k >= 14 * dv) return 5'b11101;
    p  = k / dv;
    lv = phase_lvl(p, d);
    if (dv > 1 && (k % dv) == 0 && lv[1] == 1'b0) lv[0] = phase_lvl(p - 1, d) % 2 == 1;
    return {lv, 3'b010};
  endfunction

  always @(posedge clk) begin
    int p;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) m_k[i] = -1;
      else if (m_k[i] < 0 || m_k[i] >= 14 * div_of(i)) begin
        if (valid_v[i]) begin
          m_k[i] = 0;
          m_d[i] = data_v[i];
        end else m_k[i] = -1;
      end else begin
        p = m_k[i] / div_of(i);
        if (!((i == 0) && stretch_v && (p % 2 == 0) && p >= 2 && p <= 12)) m_k[i]++;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      e = rst_n ? model_out(i, m_k[i], m_d[i]) : 5'b11100;
      if (cyc < LOGN) lg[i][cyc] = obs[i];
      n_cmp++;
      if (obs[i] !== e) begin
        n_fail++;
        $display("FAIL cycle_dut%0d cyc=%0d scl,sda,ready,busy,done got %b want %b", i, cyc, obs[i], e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no DUT response within cycle budget", name);
  endtask

  function automatic int rises_word(input int i, input int from, input int to, input int n);
    int w, cnt;
    w = 0;
    cnt = 0;
    for (int c = from + 1; c <= to && c < LOGN; c++)
      if (c > 0 && cnt < n && lg[i][c][4] && !lg[i][c-1][4]) begin
        w = (w << 1) | int'(lg[i][c][3]);
        cnt++;
      end
    return w;
  endfunction

  function automatic int count_hi(input int i, input int from, input int to, input int b);
    int n;
    n = 0;
    for (int c = from; c <= to; c++)
      if (c >= 0 && c < LOGN && lg[i][c][b]) n++;
    return n;
  endfunction

  task automatic run_frame(input int i, input logic [3:0] d, input int pulse_at,
                           input logic [3:0] pd, input int slen, output int acc, output int dn);
    int n;
    n = 0;
    acc = -1;
    dn = -1;
    while (!obs[i][2] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!obs[i][2]) begin
      timeout_fail("ready_timeout");
      return;
    end
    valid_v[i] = 1'b1;
    data_v[i]  = d;
    acc = cyc;
    for (int t = 0; t < 400 && dn < 0; t++) begin
      @(posedge clk); #1;
      valid_v[i] = ((cyc - acc) == pulse_at);
      if ((cyc - acc) == pulse_at) data_v[i] = pd;
      stretch_v = (i == 0) && (cyc - acc >= 9) && (cyc - acc < 9 + slen);
      if (obs[i][0]) dn = cyc;
    end
    stretch_v = 1'b0;
    valid_v[i] = 1'b0;
    if (dn < 0) timeout_fail("done_timeout");
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, dn, a1, a2, d2, t1_len, lastlow, dv, pa;
    logic [3:0] d;
    valid_v[0] = 1'b0;
    valid_v[1] = 1'b0;
    data_v[0]  = 4'd0;
    data_v[1]  = 4'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", obs[0], 5'b11100);
    chk("reset_b", obs[1], 5'b11100);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_start", model_out(0, 0, 4'b1010), 5'b10010);
    chk("model_bit0_hold", model_out(0, 4, 4'b1010), 5'b00010);
    chk("model_bit0_set", model_out(0, 5, 4'b1010), 5'b01010);
    chk("model_tail_hold", model_out(0, 36, 4'b1011), 5'b01010);
    chk("model_done", model_out(0, 56, 4'b1010), 5'b11101);
    chk("model_div1_bit1_hi", model_out(1, 4, 4'b1100), 5'b11010);

    // Single 1010 frame at DIV=4
    run_frame(0, 4'b1010, -1, 4'd0, 0, acc, dn);
    t1_len = dn - acc;
    chk("t1_done_latency", dn - acc, 57);
    chk("t1_busy_cycles", count_hi(0, acc, dn, 1), 56);
    chk("t1_idle_before_start", lg[0][acc][4:3], 2'b11);
    chk("t1_start_cond", lg[0][acc+1][4:3], 2'b10);
    chk("t1_rise_bits", rises_word(0, acc, dn, 5), 5'b10100);
    chk("t1_stop_hi", lg[0][dn-5][4:3], 2'b10);
    chk("t1_stop_rel", lg[0][dn-4][4:3], 2'b11);

    // Back-to-back 0000 then 1111 with valid held high
    valid_v[0] = 1'b1;
    data_v[0]  = 4'b0000;
    a1 = cyc;
    @(posedge clk); #1;
    data_v[0] = 4'b1111;
    a2 = -1;
    for (int t = 0; t < 200 && a2 < 0; t++) begin
      if (obs[0][2]) a2 = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    d2 = -1;
    for (int t = 0; t < 200 && d2 < 0; t++) begin
      if (obs[0][0]) d2 = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    if (a2 < 0 || d2 < 0) timeout_fail("t2_frames");
    else begin
      @(negedge clk);
      lastlow = a1;
      for (int c = a2 - 1; c > a1 && lastlow == a1; c--)
        if (!lg[0][c][3]) lastlow = c;
      chk("t2_accept_on_done", lg[0][a2][0], 1'b1);
      chk("t2_accept_gap", a2 - a1, 57);
      chk("t2_bus_free", a2 - 1 - lastlow, 4);
      chk("t2_start2", lg[0][a2+1][4:3], 2'b10);
      chk("t2_bits1", rises_word(0, a1, a2, 4), 4'b0000);
      chk("t2_bits2", rises_word(0, a2, d2, 4), 4'b1111);
      chk("t2_done2", d2 - a2, 57);
      @(posedge clk); #1;
    end

    // Valid pulse during a frame is ignored
    run_frame(0, 4'b1001, 10, 4'b0110, 0, acc, dn);
    chk("t3_bits", rises_word(0, acc, dn, 4), 4'b1001);
    chk("t3_ready_low", count_hi(0, acc + 1, dn - 1, 2), 0);
    chk("t3_done_latency", dn - acc, 57);

    // Reset during BIT_HI of bit 2
    valid_v[0] = 1'b1;
    data_v[0]  = 4'b1010;
    acc = cyc;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    while (cyc < acc + 26) begin
      @(posedge clk); #1;
    end
    chk("t4_pre_reset_busy", obs[0][1], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_reset_immediate", obs[0], 5'b11100);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    chk("t4_no_done", count_hi(0, acc, cyc - 1, 0), 0);
    run_frame(0, 4'b0011, -1, 4'd0, 0, acc, dn);
    chk("t4_after_bits", rises_word(0, acc, dn, 5), 5'b00110);
    chk("t4_after_latency", dn - acc, 57);

    // DIV=1
    run_frame(1, 4'b1100, -1, 4'd0, 0, acc, dn);
    chk("t5_done_latency", dn - acc, 15);
    chk("t5_busy_cycles", count_hi(1, acc, dn, 1), 14);
    chk("t5_rise_bits", rises_word(1, acc, dn, 5), 5'b11000);

`ifdef NIBBLE_SDA_TX_STRETCH_EN
    run_frame(0, 4'b1010, -1, 4'd0, 6, acc, dn);
    chk("t6_stretch_delay", (dn - acc) - t1_len, 6);
    chk("t6_bits", rises_word(0, acc, dn, 5), 5'b10100);
`endif

    // Randomized frames, gaps and ignored mid-frame valid pulses
    for (int r = 0; r < 20; r++) begin
      int ii;
      ii = $urandom_range(0, 1);
      dv = div_of(ii);
      d  = 4'($urandom_range(0, 15));
      pa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8 * dv)) : -1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_frame(ii, d, pa, 4'($urandom_range(0, 15)), 0, acc, dn);
      chk("rnd_latency", dn - acc, 14 * dv + 1);
      chk("rnd_bits", rises_word(ii, acc, dn, 4), {28'd0, d});
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule
